// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- data-cache controller between three LSQ load ports and a
// 32-entry direct-mapped cache array.  Performs zero-latency lookups through
// the array read ports, tracks misses in a small MSHR file, issues block
// loads to memory and writes returning blocks into the array (lane 0).
//
// Ports:
//   clock, reset             clock; synchronous active-high reset
//   ld_valid/ld_addr         load requests per port (byte address)
//   ld_hit/ld_data           combinational hit and block data per port
//   mshr_full                every MSHR entry is occupied
//   fill_valid/fill_blk      fill written to the array this cycle, {tag,idx}
//   rd_idx/rd_tag            array read index/tag per port
//   rd_data/rd_valid         array read data / tag-match per port
//   wr_en/wr_idx/wr_tag/wr_data  array write port (lane 0 only)
//   proc2mem_command/addr    block load request (0=NONE, 1=LOAD)
//   mem2proc_response        issue tag of the accepted request, 0 = rejected
//   mem2proc_data/tag        returning block and its tag, tag 0 = none
//
// Build option: define DCACHE_FILL_FWD_EN to forward a same-cycle fill to a
// missing load of the same block instead of making it retry.
module dcache_ctrl #(
   parameter int unsigned NUM_PORTS = 3,
   parameter int unsigned NUM_MSHR  = 4,
   parameter int unsigned IDX_BITS  = 5,
   parameter int unsigned TAG_BITS  = 8
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NUM_PORTS-1:0]               ld_valid,
   input  logic [NUM_PORTS-1:0][15:0]         ld_addr,
   output logic [NUM_PORTS-1:0]               ld_hit,
   output logic [NUM_PORTS-1:0][63:0]         ld_data,
   output logic                               mshr_full,
   output logic                               fill_valid,
   output logic [TAG_BITS+IDX_BITS-1:0]       fill_blk,
   output logic [NUM_PORTS-1:0][IDX_BITS-1:0] rd_idx,
   output logic [NUM_PORTS-1:0][TAG_BITS-1:0] rd_tag,
   input  logic [NUM_PORTS-1:0][63:0]         rd_data,
   input  logic [NUM_PORTS-1:0]               rd_valid,
   output logic [NUM_PORTS-1:0]               wr_en,
   output logic [NUM_PORTS-1:0][IDX_BITS-1:0] wr_idx,
   output logic [NUM_PORTS-1:0][TAG_BITS-1:0] wr_tag,
   output logic [NUM_PORTS-1:0][63:0]         wr_data,
   output logic [1:0]                         proc2mem_command,
   output logic [31:0]                        proc2mem_addr,
   input  logic [3:0]                         mem2proc_response,
   input  logic [63:0]                        mem2proc_data,
   input  logic [3:0]                         mem2proc_tag
);

   localparam int unsigned BLK_BITS = TAG_BITS + IDX_BITS;

   typedef enum logic {ST_ISSUE, ST_WAIT} mshr_state_e;

   logic [NUM_MSHR-1:0] valid_q, valid_d;
   mshr_state_e         state_q [NUM_MSHR];
   mshr_state_e         state_d [NUM_MSHR];
   logic [BLK_BITS-1:0] blk_q   [NUM_MSHR];
   logic [BLK_BITS-1:0] blk_d   [NUM_MSHR];
   logic [3:0]          mtag_q  [NUM_MSHR];
   logic [3:0]          mtag_d  [NUM_MSHR];

   logic [NUM_PORTS-1:0][BLK_BITS-1:0] req_blk;
   logic [NUM_PORTS-1:0]               miss;
   logic [NUM_PORTS-1:0][2:0]          addr_offset_unused;

   logic                fill_hit;
   logic [BLK_BITS-1:0] fill_sel_blk;
   logic [NUM_MSHR-1:0] fill_oh;
   logic                issue_any;
   logic [BLK_BITS-1:0] issue_blk;
   logic [NUM_MSHR-1:0] issue_oh;

   // Address split and array read-port drive.
   always_comb begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         req_blk[p]            = ld_addr[p][BLK_BITS+2:3];
         rd_idx[p]             = req_blk[p][IDX_BITS-1:0];
         rd_tag[p]             = req_blk[p][BLK_BITS-1:IDX_BITS];
         addr_offset_unused[p] = ld_addr[p][2:0];
         miss[p]               = ld_valid[p] & ~rd_valid[p];
      end
   end

   // Returning block: first waiting entry whose memory tag matches.
   always_comb begin
      fill_hit     = 1'b0;
      fill_sel_blk = '0;
      fill_oh      = '0;
      for (int unsigned e = 0; e < NUM_MSHR; e++) begin
         if (!fill_hit && valid_q[e] && state_q[e] == ST_WAIT &&
             mem2proc_tag != 4'd0 && mtag_q[e] == mem2proc_tag) begin
            fill_hit     = 1'b1;
            fill_sel_blk = blk_q[e];
            fill_oh[e]   = 1'b1;
         end
      end
   end

   // Request issue: lowest entry still waiting to be sent.
   always_comb begin
      issue_any = 1'b0;
      issue_blk = '0;
      issue_oh  = '0;
      for (int unsigned e = 0; e < NUM_MSHR; e++) begin
         if (!issue_any && valid_q[e] && state_q[e] == ST_ISSUE) begin
            issue_any   = 1'b1;
            issue_blk   = blk_q[e];
            issue_oh[e] = 1'b1;
         end
      end
   end

   always_comb begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         ld_hit[p]  = ld_valid[p] & rd_valid[p];
         ld_data[p] = rd_data[p];
`ifdef DCACHE_FILL_FWD_EN
         if (miss[p] && fill_hit && req_blk[p] == fill_sel_blk) begin
            ld_hit[p]  = 1'b1;
            ld_data[p] = mem2proc_data;
         end
`endif
      end
   end

   always_comb begin
      wr_en      = '0;
      wr_idx     = '0;
      wr_tag     = '0;
      wr_data    = '0;
      wr_en[0]   = fill_hit;
      wr_idx[0]  = fill_sel_blk[IDX_BITS-1:0];
      wr_tag[0]  = fill_sel_blk[BLK_BITS-1:IDX_BITS];
      wr_data[0] = fill_hit ? mem2proc_data : '0;
   end

   assign fill_valid       = fill_hit;
   assign fill_blk         = fill_sel_blk;
   assign mshr_full        = &valid_q;
   assign proc2mem_command = issue_any ? 2'd1 : 2'd0;
   assign proc2mem_addr    = issue_any ? 32'({issue_blk, 3'b000}) : '0;

   // Next MSHR state.  Free slots are judged on the registered valid bits,
   // so a slot released by this cycle's fill is only reusable next cycle.
   always_comb begin
      logic                dup;
      logic                placed;
      logic [NUM_MSHR-1:0] taken;
      dup     = 1'b0;
      placed  = 1'b0;
      taken   = '0;
      valid_d = valid_q;
      state_d = state_q;
      blk_d   = blk_q;
      mtag_d  = mtag_q;

      for (int unsigned e = 0; e < NUM_MSHR; e++) begin
         if (issue_oh[e] && mem2proc_response != 4'd0) begin
            state_d[e] = ST_WAIT;
            mtag_d[e]  = mem2proc_response;
         end
         if (fill_oh[e]) valid_d[e] = 1'b0;
      end

      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (miss[p]) begin
            dup = fill_hit && req_blk[p] == fill_sel_blk;
            for (int unsigned e = 0; e < NUM_MSHR; e++)
               if (valid_q[e] && blk_q[e] == req_blk[p]) dup = 1'b1;
            for (int unsigned q = 0; q < NUM_PORTS; q++)
               if (q < p && miss[q] && req_blk[q] == req_blk[p]) dup = 1'b1;
            placed = dup;
            for (int unsigned e = 0; e < NUM_MSHR; e++) begin
               if (!placed && !valid_q[e] && !taken[e]) begin
                  placed     = 1'b1;
                  taken[e]   = 1'b1;
                  valid_d[e] = 1'b1;
                  state_d[e] = ST_ISSUE;
                  blk_d[e]   = req_blk[p];
                  mtag_d[e]  = '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         for (int unsigned e = 0; e < NUM_MSHR; e++) begin
            state_q[e] <= ST_ISSUE;
            blk_q[e]   <= '0;
            mtag_q[e]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int unsigned e = 0; e < NUM_MSHR; e++) begin
            state_q[e] <= state_d[e];
            blk_q[e]   <= blk_d[e];
            mtag_q[e]  <= mtag_d[e];
         end
      end
   end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Data-cache controller that sits between the load/store queue's three load ports and the 32-entry direct-mapped data cache array. Each cycle it drives the array's three read ports for lookups and reports hits. It tracks misses in a small MSHR file and issues block loads to main memory. It writes returning memory blocks into the array through its write port and broadcasts each fill so pending loads can retry.

Parameters:
NUM_PORTS, 3, number of load lookup ports (array read ports)
NUM_MSHR, 4, outstanding miss entries
IDX_BITS, 5, cache index width (addr[7:3])
TAG_BITS, 8, cache tag width (addr[15:8])

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
ld_valid  in  [2:0]  load request valid per port
ld_addr  in  [2:0][15:0]  load byte address per port
ld_hit  out  [2:0]  load hit this cycle (combinational)
ld_data  out  [2:0][63:0]  block data for hitting port
mshr_full  out  1  no free MSHR entry
fill_valid  out  1  fill written to array this cycle
fill_blk  out  [12:0]  {tag,idx} of the fill
rd_idx  out  [2:0][4:0]  to array read index
rd_tag  out  [2:0][7:0]  to array read tag
rd_data  in  [2:0][63:0]  from array read data
rd_valid  in  [2:0]  from array tag-match valid
wr_en  out  [2:0]  to array write enables; only bit 0 used, bits 2:1 tied 0
wr_idx  out  [2:0][4:0]  write index, lane 0
wr_tag  out  [2:0][7:0]  write tag, lane 0
wr_data  out  [2:0][63:0]  write data, lane 0
proc2mem_command  out  2  0=NONE, 1=LOAD
proc2mem_addr  out  32  block address {16'b0,tag,idx,3'b0}
mem2proc_response  in  4  issue tag; 0 = request rejected
mem2proc_data  in  64  returning block
mem2proc_tag  in  4  tag of returning block; 0 = none

Behaviour:
- Address split: offset addr[2:0] (ignored), idx addr[7:3], tag addr[15:8].
- rd_idx[i]/rd_tag[i] are driven combinationally from ld_addr[i].
- ld_hit[i] = ld_valid[i] & rd_valid[i]; ld_data[i] = rd_data[i]. Hit latency is 0 cycles.
- MSHR entry fields: valid, state {ISSUE, WAIT}, blk[12:0], mtag[3:0].
- Allocation on a miss (ld_valid & !rd_valid):
  - If blk matches a valid entry or another miss this cycle, merge; no new entry.
  - Otherwise take the lowest free entry, state ISSUE. Ports are processed 0→2; at most NUM_MSHR allocations per cycle.
  - If no entry is free, the miss is dropped (ld_hit=0) and the LSQ retries.
- mshr_full = all entries valid (registered state, pre-allocation).
- Issue: the lowest-index ISSUE entry drives proc2mem_command=LOAD and proc2mem_addr in the same cycle. If mem2proc_response≠0, capture mtag and move to WAIT. If 0, stay ISSUE and retry next cycle. An entry allocated this cycle is not issued until the next cycle. No ISSUE entry → command NONE, addr 0.
- Fill: if mem2proc_tag≠0 matches a WAIT entry's mtag:
  - assert wr_en[0]; wr_idx[0]/wr_tag[0] = entry blk; wr_data[0] = mem2proc_data;
  - assert fill_valid with fill_blk = entry blk;
  - entry freed at the clock edge and reusable next cycle.
  - The written block is visible to lookups the cycle after.
  - An unmatched mem2proc_tag is ignored.
- Same-cycle miss and fill on the same blk: no allocation; see optional feature.
- Same-cycle free and allocate of one slot: the slot is not free until the next cycle.
- Reset: all MSHRs invalid; outputs proc2mem_command=0, wr_en=0, fill_valid=0, mshr_full=0. ld_hit follows ld_valid/rd_valid combinationally. An in-flight fill arriving after reset is ignored (no matching entry).

Optional Feature:
DCACHE_FILL_FWD_EN:
- Defined: a miss whose blk equals the current fill blk returns ld_hit=1 with ld_data=mem2proc_data in that cycle.
- Undefined: that port gets ld_hit=0, no allocation, and the load relies on fill_valid to retry.

Test Plan:
- Array rd_valid=3'b101 with ld_valid=3'b111 → ld_hit=3'b101, ld_data matches rd_data lanes 0 and 2.
- Port 1 misses addr 0x1238 → entry 0 allocated; next cycle proc2mem_command=1, addr=0x00001238. response=3 → WAIT. Later mem2proc_tag=3 with data 0xDEADBEEF → wr_en=3'b001, wr_idx[0]=7, wr_tag[0]=0x12, fill_valid=1.
- Ports 0 and 2 miss 0x1230 and 0x1237 in the same cycle → one MSHR allocated, one LOAD issued.
- response=0 for 3 cycles then 5 → LOAD held each cycle with a stable address; entry enters WAIT with mtag=5.
- Five distinct misses on consecutive cycles → mshr_full=1 after four; fifth allocates nothing. After one fill, mshr_full=0 and a retried miss allocates.
- Miss on a blk equal to the current fill blk → ld_hit=0 and no allocation (macro off); ld_hit=1, ld_data=mem2proc_data (DCACHE_FILL_FWD_EN on). Reset while WAIT, then mem2proc_tag arrives → no wr_en.
